// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions (state encoding, oversampling and
//               bit-timer width, timer reload helper). Used by rx and tx.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Clock cycles per bit are prescale * UART_OVERSAMPLE.
  localparam int UART_OVERSAMPLE = 8;
  // Wide enough for 8 * 65535 - 1.
  localparam int UART_TIMER_W    = 19;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  // Down-counter reload value: half = 1 gives half a bit period (4P-1),
  // otherwise a full bit period (8P-1).
  function automatic logic [UART_TIMER_W-1:0] timer_load(
    input logic [15:0] p,
    input logic        half
  );
    logic [UART_TIMER_W-1:0] w_full;
    w_full = {p, 3'b000};
    if (half) begin
      timer_load = {1'b0, w_full[UART_TIMER_W-1:1]} - UART_TIMER_W'(1);
    end else begin
      timer_load = w_full - UART_TIMER_W'(1);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for signals asynchronous to clk, with
//               a configurable reset value. rst is active-low, asynchronous.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int                 WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_q;

  // Two register stages give metastability time to resolve.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Synchronises rxd, times bits with a
//               prescaled down-counter, and delivers bytes on a valid/ready
//               output with overrun and frame-error pulses.
//               rst is active-low, asynchronous.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic [15:0]           prescale,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error
);

  import uart_pkg::*;

  localparam int C_CNT_W = $clog2(DATA_WIDTH + 1);

  logic                    w_rxd_s;
  uart_state_t             r_state;
  logic [UART_TIMER_W-1:0] r_timer;
  logic [15:0]             r_p_lat;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic [C_CNT_W-1:0]      r_bit_cnt;
  logic                    w_tick;

  // Idle-high line, so the synchroniser resets to 1 to avoid a false start.
  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync_rxd (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (w_rxd_s)
  );

  assign w_tick = (r_timer == '0);

  // Receive FSM, bit timer, shift register and output handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state            <= ST_IDLE;
      r_timer            <= '0;
      r_p_lat            <= '0;
      r_shift            <= '0;
      r_bit_cnt          <= '0;
      output_axis_tdata  <= '0;
      output_axis_tvalid <= 1'b0;
      busy               <= 1'b0;
      overrun_error      <= 1'b0;
      frame_error        <= 1'b0;
    end else begin
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;

      // Consumer handshake; a delivery in this cycle overrides the clear.
      if (output_axis_tvalid && output_axis_tready) begin
        output_axis_tvalid <= 1'b0;
      end

      if (!w_tick) begin
        r_timer <= r_timer - UART_TIMER_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          busy <= 1'b0;
          // A zero prescaler means the receiver is disabled.
          if ((prescale != 16'd0) && !w_rxd_s) begin
            r_p_lat <= prescale;
            r_timer <= timer_load(prescale, 1'b1);
            busy    <= 1'b1;
            r_state <= ST_START;
          end
        end

        ST_START: begin
          if (w_tick) begin
            if (!w_rxd_s) begin
              r_timer   <= timer_load(r_p_lat, 1'b0);
              r_bit_cnt <= C_CNT_W'(DATA_WIDTH);
              r_state   <= ST_DATA;
            end else begin
              // Line went high again before mid start bit: a glitch.
              busy    <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end

        ST_DATA: begin
          if (w_tick) begin
            r_shift   <= {w_rxd_s, r_shift[DATA_WIDTH-1:1]};
            r_timer   <= timer_load(r_p_lat, 1'b0);
            r_bit_cnt <= r_bit_cnt - C_CNT_W'(1);
            if (r_bit_cnt == C_CNT_W'(1)) begin
              r_state <= ST_STOP;
            end
          end
        end

        ST_STOP: begin
          if (w_tick) begin
            if (w_rxd_s) begin
              if (!output_axis_tvalid || output_axis_tready) begin
                output_axis_tdata  <= r_shift;
                output_axis_tvalid <= 1'b1;
              end else begin
                // Previous byte still unread: drop the new one.
                overrun_error <= 1'b1;
              end
              busy    <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              frame_error <= 1'b1;
              r_state     <= ST_BREAK;
            end
          end
        end

        ST_BREAK: begin
          // Hold off until the line returns to idle.
          if (w_rxd_s) begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Drives 8N1 frames (directed
//               and random), predicts delivery, error and busy events from
//               frame timing arithmetic, and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rxd = 1'b1;
  logic [15:0] prescale = 16'd1;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        busy;
  logic        overrun_error;
  logic        frame_error;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rdy_mode = 1;

  // Expected events keyed by cycle number.
  logic [7:0] exp_deliv [int];
  bit         exp_ferr  [int];
  bit         exp_busy  [int];

  // Output model state.
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       prev_rdy = 1'b0;
  logic       exp_ovr;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .rxd                (rxd),
    .prescale           (prescale),
    .output_axis_tdata  (tdata),
    .output_axis_tvalid (tvalid),
    .output_axis_tready (tready),
    .busy               (busy),
    .overrun_error      (overrun_error),
    .frame_error        (frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Consumer ready pattern: 0 = never, 1 = always, 2 = random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       tready = 1'b0;
        1:       tready = 1'b1;
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model and comparison, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      check("rst_tvalid", 32'(tvalid), 32'd0);
      check("rst_tdata", 32'(tdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun_error), 32'd0);
      check("rst_frame_err", 32'(frame_error), 32'd0);
    end else begin
      exp_ovr = 1'b0;
      if (exp_deliv.exists(cyc)) begin
        if (!m_valid || prev_rdy) begin
          m_data  = exp_deliv[cyc];
          m_valid = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (m_valid && prev_rdy) begin
        m_valid = 1'b0;
      end
      check("tvalid", 32'(tvalid), 32'(m_valid));
      check("tdata", 32'(tdata), 32'(m_data));
      check("overrun", 32'(overrun_error), 32'(exp_ovr));
      check("frame_err", 32'(frame_error), 32'(exp_ferr.exists(cyc)));
      if (exp_busy.exists(cyc)) check("busy", 32'(busy), 32'(exp_busy[cyc]));
    end
    prev_rdy = tready;
  end

  // One frame. The line goes low in cycle n, so the receiver first sees it
  // at t0 = n+2 and the stop-bit outcome appears at t0 + 76P + 1.
  // abort_bit >= 0 pulls reset at the start of that data bit.
  task automatic send_frame(input logic [7:0] b, input int p, input int stop_len,
                            input bit bad, input int brk_len, input int chg_p,
                            input int abort_bit);
    int n, t0, end_c, h;
    prescale = 16'(p);
    n = cyc;
    t0 = n + 2;
    end_c = t0 + 76 * p + 1;
    rxd = 1'b0;
    exp_busy[t0 + 1] = 1'b1;
    tick(8 * p);
    if (chg_p != 0) prescale = 16'(chg_p);
    for (int i = 0; i < 8; i++) begin
      if (abort_bit == i) begin
        rst = 1'b0;
        exp_deliv.delete();
        exp_ferr.delete();
        exp_busy.delete();
        tick(2);
        rxd = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(3);
        return;
      end
      rxd = b[i];
      tick(8 * p);
    end
    exp_busy[end_c - 1] = 1'b1;
    if (!bad) begin
      exp_deliv[end_c] = b;
      exp_busy[end_c] = 1'b0;
      rxd = 1'b1;
      tick(stop_len);
    end else begin
      exp_ferr[end_c] = 1'b1;
      rxd = 1'b0;
      tick(brk_len);
      h = cyc;
      rxd = 1'b1;
      exp_busy[h + 2] = 1'b1;
      exp_busy[h + 3] = 1'b0;
      tick(1);
    end
  endtask

  // Short low pulse of g <= 4P cycles: rejected at the mid-start sample.
  task automatic glitch(input int p, input int g);
    int n;
    prescale = 16'(p);
    n = cyc;
    rxd = 1'b0;
    exp_busy[n + 3] = 1'b1;
    exp_busy[n + 2 + 4 * p] = 1'b1;
    exp_busy[n + 3 + 4 * p] = 1'b0;
    tick(g);
    rxd = 1'b1;
    tick(4 * p + 1 - g);
  endtask

  initial begin
    int p, kind, stop_len, brk_len, chg_p, abort_bit;
    logic [7:0] b;

    tick(3);
    rst = 1'b1;
    tick(5);

    // Single byte, consumer always ready.
    rdy_mode = 1;
    send_frame(8'hA5, 1, 8, 1'b0, 0, 0, -1);
    tick(4);

    // Overrun: consumer stalled across two frames, then released.
    rdy_mode = 0;
    send_frame(8'h11, 2, 16, 1'b0, 0, 0, -1);
    send_frame(8'h22, 2, 16, 1'b0, 0, 0, -1);
    tick(10);
    rdy_mode = 1;
    tick(5);

    // Frame error with a 16-cycle break, then a good frame.
    send_frame(8'h3C, 1, 8, 1'b1, 16, 0, -1);
    send_frame(8'h5A, 1, 8, 1'b0, 0, 0, -1);

    // Start-bit glitch.
    glitch(4, 2);

    // Reset in the middle of the data bits, then recovery.
    send_frame(8'hFF, 1, 8, 1'b0, 0, 0, 3);
    send_frame(8'h81, 1, 8, 1'b0, 0, 0, -1);

    // Prescaler change mid-frame only affects the next frame.
    send_frame(8'h96, 2, 16, 1'b0, 0, 3, -1);
    send_frame(8'h69, 3, 24, 1'b0, 0, 0, -1);

    // Back-to-back frames with the shortest stop bit the receiver accepts.
    rdy_mode = 2;
    send_frame(8'h01, 1, 5, 1'b0, 0, 0, -1);
    send_frame(8'hFE, 1, 5, 1'b0, 0, 0, -1);
    send_frame(8'h7E, 2, 9, 1'b0, 0, 0, -1);
    tick(4);

    // Zero prescaler: line activity ignored.
    prescale = 16'd0;
    for (int i = cyc + 1; i < cyc + 24; i++) exp_busy[i] = 1'b0;
    rxd = 1'b0;
    tick(20);
    rxd = 1'b1;
    tick(4);
    prescale = 16'd1;
    tick(2);

    // Random frames.
    for (int f = 0; f < 40; f++) begin
      p = $urandom_range(1, 3);
      b = 8'($urandom);
      rdy_mode = $urandom_range(0, 2);
      kind = $urandom_range(0, 11);
      stop_len = ($urandom_range(0, 1) == 1) ? 4 * p + 1 : 8 * p + $urandom_range(0, 10);
      brk_len = 4 * p + 1 + $urandom_range(0, 20);
      chg_p = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0;
      abort_bit = (kind == 1) ? $urandom_range(0, 7) : -1;
      if (kind == 0) glitch(p, $urandom_range(1, 4 * p));
      else send_frame(b, p, stop_len, (kind == 2 || kind == 3), brk_len, chg_p, abort_bit);
    end

    rdy_mode = 1;
    tick(20);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
